muldiv_iter: RTL

Iterative RV32M multiply/divide responder for the execute stage. Accepts one operation over a level-held `op_valid`/`op_ready` handshake and computes it with a radix-2 shift-add multiplier or restoring divider. While `op_valid` is high and `op_ready` is low, the execute stage holds itself via its hazard output. Division by zero and signed overflow complete on a one-cycle fast path.

---
 rtl/muldiv_iter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative RV32M multiply/divide unit (radix-2 shift-add / restoring divide)
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_stall,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] op_out
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [2:0]  op_r;
    logic [31:0] opnd;      // multiplicand or divisor magnitude
    logic [63:0] acc;       // product accumulator or remainder/quotient pair
    logic        res_neg;   // final value must be negated on entry to DONE

    // Operand decode at capture: signedness, magnitudes and fast-path detection
    logic        sgn1, sgn2, s1, s2;
    logic [31:0] mag1, mag2;
    logic        div_zero, div_ovf;
    logic [31:0] special_res;
    logic        neg_in;

    always_comb begin
        sgn1        = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        sgn2        = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        s1          = sgn1 & op1[31];
        s2          = sgn2 & op2[31];
        mag1        = s1 ? (32'd0 - op1) : op1;
        mag2        = s2 ? (32'd0 - op2) : op2;
        div_zero    = op[2] && (op2 == 32'd0);
        div_ovf     = op[2] && !op[0] && (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);
        // op[1] distinguishes REM/REMU from DIV/DIVU within the divide group
        if (div_zero)
            special_res = op[1] ? op1 : 32'hFFFF_FFFF;
        else
            special_res = op[1] ? 32'd0 : 32'h8000_0000;
        // remainder takes the dividend's sign, everything else the xor of both
        neg_in      = (op[2] && op[1]) ? s1 : (s1 ^ s2);
    end

    // One iteration of the shift-add multiplier and restoring divider
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_part;
    logic [31:0] div_diff;
    logic        div_ge;
    logic [63:0] div_next;
    logic [63:0] next_acc;
    logic [63:0] prod_signed;
    logic [31:0] div_val;
    logic [31:0] result;

    always_comb begin
        mul_sum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        mul_next    = {mul_sum, acc[31:1]};
        // partial remainder after the left shift can need 33 bits
        div_part    = acc[63:31];
        div_ge      = div_part >= {1'b0, opnd};
        div_diff    = div_part[31:0] - opnd;
        div_next    = div_ge ? {div_diff, acc[30:0], 1'b1}
                             : {div_part[31:0], acc[30:0], 1'b0};
        next_acc    = op_r[2] ? div_next : mul_next;
        prod_signed = res_neg ? (64'd0 - next_acc) : next_acc;
        div_val     = op_r[1] ? next_acc[63:32] : next_acc[31:0];
        if (op_r[2])
            result = res_neg ? (32'd0 - div_val) : div_val;
        else if (op_r[1:0] == 2'b00)
            result = prod_signed[31:0];
        else
            result = prod_signed[63:32];
    end

    // Result is offered only while the requester is still asking and not stalled
    always_comb begin
        op_ready = (state == DONE) && op_valid && !op_stall;
    end

    // Control FSM together with the datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            op_r    <= 3'd0;
            opnd    <= 32'd0;
            acc     <= 64'd0;
            res_neg <= 1'b0;
            op_out  <= 32'd0;
        end else if (!op_stall) begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        op_r    <= op;
                        cnt     <= 5'd0;
                        res_neg <= neg_in;
                        if (op[2]) begin
                            opnd <= mag2;
                            acc  <= {32'd0, mag1};
                        end else begin
                            opnd <= mag1;
                            acc  <= {32'd0, mag2};
                        end
                        if (div_zero || div_ovf) begin
                            op_out <= special_res;
                            state  <= DONE;
                        end else begin
                            state  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (!op_valid) begin
                        state <= IDLE;
                    end else begin
                        acc <= next_acc;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            op_out <= result;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    // either the handshake completes or the request was flushed
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
